// File: rtl/flash_sequencer.sv
// rtl/flash_sequencer.sv - thermometer LED up/down phase sequencer with round-robin flick rewind
module flash_sequencer #(
    parameter int LED_W = 16,
    parameter int NPH   = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       flick_req,
    output logic [1:0]       flick_gnt,
    input  logic             cfg_we,
    input  logic [2:0]       cfg_addr,
    input  logic [4:0]       cfg_data,
    output logic [LED_W-1:0] led,
    output logic [2:0]       phase,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {IDLE, UP, DOWN} state_t;

    state_t      state_q;
    logic [4:0]  n_q;
    logic [2:0]  phase_q;
    logic        done_q;
    logic [1:0]  gnt_q;
    logic        rr_q;
    logic [4:0]  bound_q [NPH];
    logic [4:0]  flick_pt_q;

    logic [4:0]  cur_bound;
    logic [4:0]  cfg_clip;
    logic        any_req;
    logic        win;
    logic        last_phase;
    logic        eligible;

    function automatic logic [4:0] default_bound(input int idx);
        case (idx % 6)
            0:       default_bound = 5'd16;
            1:       default_bound = 5'd5;
            2:       default_bound = 5'd11;
            3:       default_bound = 5'd0;
            4:       default_bound = 5'd6;
            default: default_bound = 5'd0;
        endcase
    endfunction

    assign cur_bound  = bound_q[phase_q];
    assign cfg_clip   = (cfg_data > 5'd16) ? 5'd16 : cfg_data;
    assign any_req    = |flick_req;
    assign win        = flick_req[rr_q] ? rr_q : ~rr_q;
    assign last_phase = (phase_q == 3'(NPH - 1));
    // A flick rewinds one phase only from a descending, non-final phase at an anchor count.
    assign eligible   = (state_q == DOWN) && !last_phase && any_req &&
                        ((n_q == 5'd0) || (n_q == flick_pt_q));

    always_comb begin
        led = '0;
        for (int i = 0; i < LED_W; i++) begin
            led[i] = (i < int'(n_q));
        end
    end

    assign phase     = phase_q;
    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign flick_gnt = gnt_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            n_q        <= 5'd0;
            phase_q    <= 3'd0;
            done_q     <= 1'b0;
            gnt_q      <= 2'b00;
            rr_q       <= 1'b0;
            flick_pt_q <= 5'd5;
            for (int i = 0; i < NPH; i++) begin
                bound_q[i] <= default_bound(i);
            end
        end else begin
            done_q <= 1'b0;
            gnt_q  <= 2'b00;
            if (cfg_we) begin
                if (cfg_addr < 3'(NPH)) begin
                    bound_q[cfg_addr] <= cfg_clip;
                end else if (cfg_addr == 3'd6) begin
                    flick_pt_q <= cfg_clip;
                end
            end
            case (state_q)
                IDLE: begin
                    if (start || any_req) begin
                        state_q <= UP;
                        n_q     <= 5'd0;
                        phase_q <= 3'd0;
                        if (any_req) begin
                            gnt_q <= win ? 2'b10 : 2'b01;
                            rr_q  <= ~win;
                        end
                    end
                end
                UP: begin
                    if (n_q < cur_bound) begin
                        n_q <= n_q + 5'd1;
                    end else if (last_phase) begin
                        state_q <= IDLE;
                        n_q     <= 5'd0;
                        phase_q <= 3'd0;
                        done_q  <= 1'b1;
                    end else begin
                        phase_q <= phase_q + 3'd1;
                        state_q <= DOWN;
                    end
                end
                DOWN: begin
                    if (eligible) begin
                        phase_q <= phase_q - 3'd1;
                        state_q <= UP;
                        gnt_q   <= win ? 2'b10 : 2'b01;
                        rr_q    <= ~win;
                    end else if (n_q > cur_bound) begin
                        n_q <= n_q - 5'd1;
                    end else if (last_phase) begin
                        state_q <= IDLE;
                        n_q     <= 5'd0;
                        phase_q <= 3'd0;
                        done_q  <= 1'b1;
                    end else begin
                        phase_q <= phase_q + 3'd1;
                        state_q <= UP;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_flash_sequencer.sv
// tb/tb_flash_sequencer.sv - scoreboard bench for flash_sequencer with a behavioural reference model
module tb_flash_sequencer;

    localparam int NPH = 6;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  flick_req;
    logic [1:0]  flick_gnt;
    logic        cfg_we;
    logic [2:0]  cfg_addr;
    logic [4:0]  cfg_data;
    logic [15:0] led;
    logic [2:0]  phase;
    logic        busy;
    logic        done;

    always #5 clk = ~clk;

    flash_sequencer #(.LED_W(16), .NPH(NPH)) dut (
        .clk(clk), .reset(reset), .start(start), .flick_req(flick_req),
        .flick_gnt(flick_gnt), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
        .cfg_data(cfg_data), .led(led), .phase(phase), .busy(busy), .done(done)
    );

    typedef struct packed {
        logic [15:0] led;
        logic [2:0]  phase;
        logic        busy;
        logic        done;
        logic [1:0]  gnt;
    } obs_t;

    obs_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model: running flag, phase, count; direction follows phase parity.
    bit m_run;
    int m_phase, m_n, m_ptr, m_fpt;
    int m_bound[NPH];

    function automatic obs_t mk(input bit d, input logic [1:0] g);
        obs_t o;
        o.led   = 16'((32'd1 << m_n) - 32'd1);
        o.phase = 3'(m_phase);
        o.busy  = m_run;
        o.done  = d;
        o.gnt   = g;
        return o;
    endfunction

    task automatic model_reset();
        m_run = 0; m_phase = 0; m_n = 0; m_ptr = 0; m_fpt = 5;
        m_bound = '{16, 5, 11, 0, 6, 0};
    endtask

    task automatic pick(output logic [1:0] g);
        int w;
        w     = flick_req[m_ptr] ? m_ptr : 1 - m_ptr;
        g     = (w == 1) ? 2'b10 : 2'b01;
        m_ptr = 1 - w;
    endtask

    task automatic model_step();
        bit          d;
        logic [1:0]  g;
        bit          req;
        bit          desc;
        int          b;
        int          v;
        d = 0; g = 2'b00;
        req = (flick_req != 2'b00);
        if (!m_run) begin
            if (start || req) begin
                if (req) pick(g);
                m_run = 1; m_phase = 0; m_n = 0;
            end
        end else begin
            desc = (m_phase % 2) == 1;
            b    = m_bound[m_phase];
            if (desc && m_phase != NPH - 1 && (m_n == 0 || m_n == m_fpt) && req) begin
                pick(g);
                m_phase = m_phase - 1;
            end else if (!desc && m_n < b) begin
                m_n = m_n + 1;
            end else if (desc && m_n > b) begin
                m_n = m_n - 1;
            end else if (m_phase == NPH - 1) begin
                m_run = 0; m_phase = 0; m_n = 0; d = 1;
            end else begin
                m_phase = m_phase + 1;
            end
        end
        if (cfg_we) begin
            v = (cfg_data > 16) ? 16 : int'(cfg_data);
            if (cfg_addr < 6) m_bound[cfg_addr] = v;
            else if (cfg_addr == 6) m_fpt = v;
        end
        exp_q.push_back(mk(d, g));
    endtask

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            model_reset();
            exp_q.delete();
            exp_q.push_back(mk(1'b0, 2'b00));
        end else begin
            model_step();
        end
    end

    always @(negedge clk) begin : monitor
        obs_t e;
        obs_t a;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = {led, phase, busy, done, flick_gnt};
            n_checks++;
            if (a !== e) begin
                n_fail++;
                $display("FAIL scoreboard t=%0t: got led=%h phase=%0d busy=%b done=%b gnt=%b, expected led=%h phase=%0d busy=%b done=%b gnt=%b",
                         $time, a.led, a.phase, a.busy, a.done, a.gnt, e.led, e.phase, e.busy, e.done, e.gnt);
            end
        end
    end

    task automatic check(input string name, input int act, input int expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, expv, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_for(input int ph, input logic [15:0] l, input int maxc, input string name);
        for (int i = 0; i < maxc; i++) begin
            if (phase == 3'(ph) && led == l) break;
            tick();
        end
        check(name, int'(phase == 3'(ph) && led == l), 1);
    endtask

    task automatic wait_done(input int maxc, output int cyc);
        cyc = 0;
        while (cyc < maxc && !done) begin
            tick();
            cyc++;
        end
    endtask

    task automatic cfg_write(input logic [2:0] a, input logic [4:0] d);
        cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
        tick();
        cfg_we = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        bit saw;
        reset = 1'b0; start = 1'b0; flick_req = 2'b00;
        cfg_we = 1'b0; cfg_addr = 3'd0; cfg_data = 5'd0;
        repeat (3) @(posedge clk);
        #1;
        check("reset led", int'(led), 0);
        check("reset busy", int'(busy), 0);
        check("reset phase", int'(phase), 0);
        @(negedge clk) reset = 1'b1;
        tick();

        // Default run: done 62 edges after the start-sampling edge.
        pulse_start();
        wait_done(100, cyc);
        check("default run length", cyc, 62);
        tick();

        // Flick by requester 1 in phase 1 at n=5.
        pulse_start();
        wait_for(1, 16'h001F, 100, "reach p1 n5");
        flick_req = 2'b10;
        tick();
        check("flick gnt", int'(flick_gnt), 2);
        check("flick phase", int'(phase), 0);
        check("flick n held", int'(led), 16'h001F);
        flick_req = 2'b00;
        wait_for(0, 16'hFFFF, 40, "climb after flick");
        wait_done(200, cyc);
        check("flick run done", int'(done), 1);
        tick();

        // Both requesting: pointer at 0 grants requester 0, then requester 1.
        pulse_start();
        wait_for(1, 16'h001F, 100, "rr reach p1 n5");
        flick_req = 2'b11;
        tick();
        check("rr first gnt", int'(flick_gnt), 1);
        flick_req = 2'b10;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (flick_gnt != 2'b00) break;
        end
        check("rr second gnt", int'(flick_gnt), 2);
        flick_req = 2'b00;
        wait_done(200, cyc);
        tick();

        // Flick in final phase is ignored.
        pulse_start();
        wait_for(5, 16'h003F, 100, "reach p5");
        flick_req = 2'b01;
        saw = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (flick_gnt != 2'b00) saw = 1;
            if (done) break;
        end
        flick_req = 2'b00;
        check("final phase no gnt", int'(saw), 0);
        check("final phase done", int'(done), 1);
        tick();
        check("idle after done", int'(busy), 0);

        // Config: clipping and mid-phase bound change.
        cfg_write(3'd0, 5'd20);
        pulse_start();
        wait_for(0, 16'hFFFF, 30, "clip climb");
        tick();
        check("clip bound phase", int'(phase), 1);
        check("clip bound led", int'(led), 16'hFFFF);
        wait_done(200, cyc);
        tick();
        pulse_start();
        wait_for(0, 16'h007F, 20, "reach n7");
        cfg_write(3'd0, 5'd3);
        check("cfg n8 led", int'(led), 16'h00FF);
        check("cfg n8 phase", int'(phase), 0);
        tick();
        check("cfg early end phase", int'(phase), 1);
        check("cfg early end led", int'(led), 16'h00FF);
        wait_done(200, cyc);
        tick();
        cfg_write(3'd0, 5'd16);

        // Reset mid-run, then the default table must be back.
        cfg_write(3'd2, 5'd7);
        pulse_start();
        wait_for(2, 16'h001F, 100, "reach p2");
        #1 reset = 1'b0;
        #1;
        check("mid reset led", int'(led), 0);
        check("mid reset busy", int'(busy), 0);
        tick();
        check("mid reset no done", int'(done), 0);
        @(negedge clk) reset = 1'b1;
        tick();
        pulse_start();
        wait_done(100, cyc);
        check("restored run length", cyc, 62);
        tick();

        // Random traffic against the reference model.
        for (int i = 0; i < 1500; i++) begin
            start     = ($urandom_range(0, 15) == 0);
            flick_req = {($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0)};
            cfg_we    = ($urandom_range(0, 31) == 0);
            cfg_addr  = 3'($urandom_range(0, 7));
            cfg_data  = 5'($urandom_range(0, 31));
            tick();
        end
        start = 1'b0; flick_req = 2'b00; cfg_we = 1'b0;
        tick();
        check("scoreboard depth", exp_q.size(), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
